lcd_multi_field_ctrl: RTL and testbench

- Parametrised HD44780-style 2x16 character LCD controller; 8-bit bus, write-only.
- Runs a one-time power-up and init sequence, then continuously refreshes two rows of NUM_CH numeric fields.
- Row 0 shows 'R' plus the live channel values; row 1 shows 'M' plus the per-channel maxima.
- Uses real enable-pulse and command-wait timing instead of a free-running toggle.
- Sits between the measurement/max-hold logic and the board LCD pins.

---
 rtl/lcd_multi_field_ctrl_if.sv | 25 ++
 rtl/lcd_multi_field_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_lcd_multi_field_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_multi_field_ctrl_if.sv
// rtl/lcd_multi_field_ctrl_if.sv - digit inputs and LCD pin bundle for lcd_multi_field_ctrl
interface lcd_multi_field_ctrl_if #(
  parameter int NUM_CH = 4
);
  logic [8*NUM_CH-1:0] cur_tens;
  logic [8*NUM_CH-1:0] cur_ones;
  logic [8*NUM_CH-1:0] max_tens;
  logic [8*NUM_CH-1:0] max_ones;
  logic [7:0]          lcd_d;
  logic                lcd_rs;
  logic                lcd_rw;
  logic                lcd_e;
  logic                init_done;
  logic                frame_done;

  modport master (
    input  cur_tens, cur_ones, max_tens, max_ones,
    output lcd_d, lcd_rs, lcd_rw, lcd_e, init_done, frame_done
  );

  modport slave (
    output cur_tens, cur_ones, max_tens, max_ones,
    input  lcd_d, lcd_rs, lcd_rw, lcd_e, init_done, frame_done
  );
endinterface

// File: rtl/lcd_multi_field_ctrl.sv
// rtl/lcd_multi_field_ctrl.sv - HD44780 2x16 controller refreshing live and max digit rows
// Optional macro LCD_BLANK_ZERO_EN: a tens digit '0' is shown as a space.
module lcd_multi_field_ctrl #(
  parameter int NUM_CH          = 4,
  parameter int E_CYCLES        = 25,
  parameter int CMD_WAIT_CYCLES = 2500,
  parameter int CLR_WAIT_CYCLES = 100000,
  parameter int POWERON_CYCLES  = 750000
) (
  input logic                    clk_50,
  input logic                    reset,
  lcd_multi_field_ctrl_if.master bus
);

  generate
    if (NUM_CH < 1 || NUM_CH > 4) begin : g_num_ch_check
      $fatal(1, "lcd_multi_field_ctrl: NUM_CH must be in 1..4");
    end
  endgenerate

  typedef enum logic [2:0] {PWR_WAIT, INIT, ADDR0, ROW0, ADDR1, ROW1} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  localparam logic [4:0]  ROW_LAST = 5'(4*NUM_CH - 1);
  localparam logic [31:0] PWR_LAST = 32'(POWERON_CYCLES - 1);
  localparam logic [31:0] E_LAST   = 32'(E_CYCLES - 1);
  localparam logic [31:0] CMD_LAST = 32'(CMD_WAIT_CYCLES - 1);
  localparam logic [31:0] CLR_LAST = 32'(CLR_WAIT_CYCLES - 1);

  state_t              state_q, state_d, nb_state;
  phase_t              phase_q, phase_d;
  logic [31:0]         cnt_q, cnt_d, wait_last;
  logic [4:0]          idx_q, idx_d, nb_idx;
  logic [7:0]          d_q, d_d;
  logic                rs_q, rs_d, e_q, e_d, init_q, init_d, fd_q, fd_d;
  logic                snap_en, start_byte;
  logic [8*NUM_CH-1:0] ct_q, co_q, mt_q, mo_q;

  // Byte for a given position; rows read the frame snapshot, not the live inputs.
  function automatic logic [7:0] byte_for(input state_t s, input logic [4:0] i,
                                          input logic [8*NUM_CH-1:0] tens,
                                          input logic [8*NUM_CH-1:0] ones);
    logic [7:0] t_a [4];
    logic [7:0] o_a [4];
    logic [3:0] j;
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      t_a[k] = 8'h20;
      o_a[k] = 8'h20;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      t_a[k] = tens[8*k +: 8];
      o_a[k] = ones[8*k +: 8];
    end
    j = i[3:0] - 4'd1;
    b = 8'h00;
    case (s)
      INIT: begin
        case (i)
          5'd0:    b = 8'h38;
          5'd1:    b = 8'h08;
          5'd2:    b = 8'h01;
          5'd3:    b = 8'h06;
          default: b = 8'h0C;
        endcase
      end
      ADDR0: b = 8'h80;
      ADDR1: b = 8'hC0;
      ROW0, ROW1: begin
        if (i == 5'd0) begin
          b = (s == ROW0) ? 8'h52 : 8'h4D;
        end else begin
          case (j[1:0])
            2'd0: begin
              b = t_a[j[3:2]];
`ifdef LCD_BLANK_ZERO_EN
              if (b == 8'h30) b = 8'h20;
`endif
            end
            2'd1:    b = 8'h2E;
            2'd2:    b = o_a[j[3:2]];
            default: b = 8'h20;
          endcase
        end
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    d_d        = d_q;
    rs_d       = rs_q;
    e_d        = e_q;
    init_d     = init_q;
    fd_d       = 1'b0;
    snap_en    = 1'b0;
    start_byte = 1'b0;
    nb_state   = state_q;
    nb_idx     = idx_q;
    wait_last  = (!rs_q && d_q == 8'h01) ? CLR_LAST : CMD_LAST;

    if (state_q == PWR_WAIT) begin
      if (cnt_q == PWR_LAST) begin
        start_byte = 1'b1;
        nb_state   = INIT;
        nb_idx     = 5'd0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end else begin
      case (phase_q)
        PH_SETUP: begin
          phase_d = PH_PULSE;
          e_d     = 1'b1;
          cnt_d   = 32'd0;
        end
        PH_PULSE: begin
          if (cnt_q == E_LAST) begin
            phase_d = PH_WAIT;
            e_d     = 1'b0;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        PH_WAIT: begin
          if (cnt_q == wait_last) begin
            start_byte = 1'b1;
            nb_idx     = idx_q + 5'd1;
            case (state_q)
              INIT: begin
                if (idx_q == 5'd4) begin
                  nb_state = ADDR0;
                  nb_idx   = 5'd0;
                  init_d   = 1'b1;
                  snap_en  = 1'b1;
                end
              end
              ADDR0: begin
                nb_state = ROW0;
                nb_idx   = 5'd0;
              end
              ROW0: begin
                if (idx_q == ROW_LAST) begin
                  nb_state = ADDR1;
                  nb_idx   = 5'd0;
                end
              end
              ADDR1: begin
                nb_state = ROW1;
                nb_idx   = 5'd0;
              end
              ROW1: begin
                if (idx_q == ROW_LAST) begin
                  nb_state = ADDR0;
                  nb_idx   = 5'd0;
                  fd_d     = 1'b1;
                  snap_en  = 1'b1;
                end
              end
              default: nb_state = PWR_WAIT;
            endcase
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: phase_d = PH_SETUP;
      endcase
    end

    if (start_byte) begin
      state_d = nb_state;
      idx_d   = nb_idx;
      phase_d = PH_SETUP;
      cnt_d   = 32'd0;
      e_d     = 1'b0;
      rs_d    = (nb_state == ROW0) || (nb_state == ROW1);
      d_d     = byte_for(nb_state, nb_idx,
                         (nb_state == ROW1) ? mt_q : ct_q,
                         (nb_state == ROW1) ? mo_q : co_q);
    end
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state_q <= PWR_WAIT;
      phase_q <= PH_SETUP;
      cnt_q   <= 32'd0;
      idx_q   <= 5'd0;
      d_q     <= 8'h00;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      init_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      init_q  <= init_d;
      fd_q    <= fd_d;
    end
  end

  // Snapshot taken on every entry to ADDR0 keeps both rows of a frame coherent.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      ct_q <= '0;
      co_q <= '0;
      mt_q <= '0;
      mo_q <= '0;
    end else if (snap_en) begin
      ct_q <= bus.cur_tens;
      co_q <= bus.cur_ones;
      mt_q <= bus.max_tens;
      mo_q <= bus.max_ones;
    end
  end

  assign bus.lcd_d      = d_q;
  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_e      = e_q;
  assign bus.init_done  = init_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_lcd_multi_field_ctrl.sv
// tb/tb_lcd_multi_field_ctrl.sv - scoreboard bench for lcd_multi_field_ctrl (NUM_CH=4 and NUM_CH=2)
module tb_lcd_multi_field_ctrl;
  localparam int E_C   = 2;
  localparam int CMD_W = 4;
  localparam int CLR_W = 10;
  localparam int PWR   = 20;

  logic clk_50 = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_50 = ~clk_50;

  lcd_multi_field_ctrl_if #(.NUM_CH(4)) bus4 ();
  lcd_multi_field_ctrl_if #(.NUM_CH(2)) bus2 ();

  lcd_multi_field_ctrl #(
    .NUM_CH(4), .E_CYCLES(E_C), .CMD_WAIT_CYCLES(CMD_W),
    .CLR_WAIT_CYCLES(CLR_W), .POWERON_CYCLES(PWR)
  ) dut4 (
    .clk_50(clk_50),
    .reset (reset),
    .bus   (bus4)
  );

  lcd_multi_field_ctrl #(
    .NUM_CH(2), .E_CYCLES(E_C), .CMD_WAIT_CYCLES(CMD_W),
    .CLR_WAIT_CYCLES(CLR_W), .POWERON_CYCLES(PWR)
  ) dut2 (
    .clk_50(clk_50),
    .reset (reset),
    .bus   (bus2)
  );

  int checks   = 0;
  int failures = 0;
  logic [8:0] q4[$];
  logic [8:0] q2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int which, input logic rs, input logic [7:0] d);
    if (which == 4) q4.push_back({rs, d});
    else            q2.push_back({rs, d});
  endtask

  task automatic push_init(input int which);
    push_byte(which, 1'b0, 8'h38);
    push_byte(which, 1'b0, 8'h08);
    push_byte(which, 1'b0, 8'h01);
    push_byte(which, 1'b0, 8'h06);
    push_byte(which, 1'b0, 8'h0C);
  endtask

  task automatic push_row(input int which, input int nch, input logic [7:0] lead,
                          input logic [31:0] tens, input logic [31:0] ones);
    logic [7:0] t;
    push_byte(which, 1'b1, lead);
    for (int k = 0; k < nch; k++) begin
      t = tens[8*k +: 8];
`ifdef LCD_BLANK_ZERO_EN
      if (t == 8'h30) t = 8'h20;
`endif
      push_byte(which, 1'b1, t);
      push_byte(which, 1'b1, 8'h2E);
      push_byte(which, 1'b1, ones[8*k +: 8]);
      if (k < nch - 1) push_byte(which, 1'b1, 8'h20);
    end
  endtask

  task automatic push_frame(input int which, input int nch,
                            input logic [31:0] ct, input logic [31:0] co,
                            input logic [31:0] mt, input logic [31:0] mo);
    push_byte(which, 1'b0, 8'h80);
    push_row(which, nch, 8'h52, ct, co);
    push_byte(which, 1'b0, 8'hC0);
    push_row(which, nch, 8'h4D, mt, mo);
  endtask

  // Bytes are captured on the E falling edge and compared against the scoreboard.
  logic prev_e4 = 1'b0, prev_e2 = 1'b0, prev_fd4 = 1'b0, prev_fd2 = 1'b0;
  int fd_high4 = 0, fd_rise4 = 0, fd_high2 = 0, fd_rise2 = 0;
  logic [8:0] ex4, ex2;

  always @(negedge clk_50) begin
    if (prev_e4 && !bus4.lcd_e && q4.size() > 0) begin
      ex4 = q4.pop_front();
      chk("dut4_byte", {23'd0, bus4.lcd_rs, bus4.lcd_d}, {23'd0, ex4});
    end
    if (prev_e2 && !bus2.lcd_e && q2.size() > 0) begin
      ex2 = q2.pop_front();
      chk("dut2_byte", {23'd0, bus2.lcd_rs, bus2.lcd_d}, {23'd0, ex2});
    end
    if (bus4.frame_done) fd_high4++;
    if (bus4.frame_done && !prev_fd4) fd_rise4++;
    if (bus2.frame_done) fd_high2++;
    if (bus2.frame_done && !prev_fd2) fd_rise2++;
    prev_e4  = bus4.lcd_e;
    prev_e2  = bus2.lcd_e;
    prev_fd4 = bus4.frame_done;
    prev_fd2 = bus2.frame_done;
  end

  localparam logic [31:0] CT_A = 32'h37353331;  // tens '1','3','5','7'
  localparam logic [31:0] CO_A = 32'h38363432;  // ones '2','4','6','8'
  localparam logic [31:0] CT_B = 32'h37353031;  // ch1 tens '0'
  localparam logic [31:0] MT_A = 32'h39383939;  // ch0 max tens '9'
  localparam logic [31:0] MT_B = 32'h39383933;  // ch0 max tens '3'
  localparam logic [31:0] MO_A = 32'h39393939;

  int cyc;
  int w;
  int gaps [5] = '{5, 5, 11, 5, 5};

  initial begin
    bus4.cur_tens = CT_A;  bus4.cur_ones = CO_A;
    bus4.max_tens = MT_A;  bus4.max_ones = MO_A;
    bus2.cur_tens = 16'h3331; bus2.cur_ones = 16'h3432;
    bus2.max_tens = 16'h3939; bus2.max_ones = 16'h3939;
    repeat (3) @(negedge clk_50);

    chk("rst_lcd_e", {31'd0, bus4.lcd_e}, 32'd0);
    chk("rst_lcd_d", {24'd0, bus4.lcd_d}, 32'd0);
    chk("rst_lcd_rs", {31'd0, bus4.lcd_rs}, 32'd0);
    chk("rst_init_done", {31'd0, bus4.init_done}, 32'd0);
    chk("rst_frame_done", {31'd0, bus4.frame_done}, 32'd0);

    push_init(4);
    push_frame(4, 4, CT_A, CO_A, MT_A, MO_A);
    push_init(2);
    push_frame(2, 2, 32'h3331, 32'h3432, 32'h3939, 32'h3939);

    @(posedge clk_50);
    #1 reset = 1'b1;
    cyc = 0;
    while (!bus4.lcd_e && cyc < 200) begin
      @(posedge clk_50); #1;
      cyc++;
    end
    chk("pwr_idle_clocks", cyc, PWR + 1);
    chk("init_done_during_init", {31'd0, bus4.init_done}, 32'd0);

    for (int b = 0; b < 5; b++) begin
      w = 0;
      while (bus4.lcd_e && w < 50) begin
        @(posedge clk_50); #1;
        w++;
      end
      chk("e_pulse_width", w, E_C);
      w = 0;
      while (!bus4.lcd_e && w < 100) begin
        @(posedge clk_50); #1;
        w++;
      end
      chk("e_low_gap", w, gaps[b]);
    end
    chk("first_addr0_byte", {23'd0, bus4.lcd_rs, bus4.lcd_d}, 32'h080);
    chk("init_done_before_80", {31'd0, bus4.init_done}, 32'd1);

    // Change a max digit during ROW0: this frame keeps '9', the next one shows '3'.
    for (int i = 0; i < 200 && bus4.lcd_rs !== 1'b1; i++) @(negedge clk_50);
    chk("wait_row0_f1", {31'd0, bus4.lcd_rs}, 32'd1);
    bus4.max_tens = MT_B;
    push_frame(4, 4, CT_A, CO_A, MT_B, MO_A);

    for (int i = 0; i < 1000 && bus4.frame_done !== 1'b1; i++) @(negedge clk_50);
    chk("wait_frame_done_f1", {31'd0, bus4.frame_done}, 32'd1);
    for (int i = 0; i < 200 && bus4.lcd_rs !== 1'b1; i++) @(negedge clk_50);
    chk("wait_row0_f2", {31'd0, bus4.lcd_rs}, 32'd1);
    bus4.cur_tens = CT_B;
    push_frame(4, 4, CT_B, CO_A, MT_B, MO_A);

    for (int i = 0; i < 2000 && q4.size() != 0; i++) @(negedge clk_50);
    chk("q4_drained", q4.size(), 0);
    chk("q2_drained", q2.size(), 0);
    for (int i = 0; i < 50 && bus4.frame_done !== 1'b1; i++) @(negedge clk_50);
    @(negedge clk_50);
    chk("frame_done_pulses", fd_rise4, 3);
    chk("frame_done_high_clocks", fd_high4, 3);
    chk("dut2_frame_done_width", fd_high2, fd_rise2);

    for (int i = 0; i < 100 && bus4.lcd_e !== 1'b1; i++) @(negedge clk_50);
    chk("wait_e_high", {31'd0, bus4.lcd_e}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_lcd_e", {31'd0, bus4.lcd_e}, 32'd0);
    chk("abort_lcd_d", {24'd0, bus4.lcd_d}, 32'd0);
    chk("abort_init_done", {31'd0, bus4.init_done}, 32'd0);
    repeat (3) @(negedge clk_50);
    push_init(4);
    push_byte(4, 1'b0, 8'h80);
    push_init(2);
    push_byte(2, 1'b0, 8'h80);

    @(posedge clk_50);
    #1 reset = 1'b1;
    cyc = 0;
    while (!bus4.lcd_e && cyc < 200) begin
      @(posedge clk_50); #1;
      cyc++;
    end
    chk("replay_idle_clocks", cyc, PWR + 1);
    for (int i = 0; i < 500 && (q4.size() != 0 || q2.size() != 0); i++) @(negedge clk_50);
    chk("replay_q4_drained", q4.size(), 0);
    chk("replay_q2_drained", q2.size(), 0);
    chk("lcd_rw4", {31'd0, bus4.lcd_rw}, 32'd0);
    chk("lcd_rw2", {31'd0, bus2.lcd_rw}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
